game_engine: RTL and testbench

//  Parametrised Flappy Bird game core: one-hot game FSM, bird physics (gravity/flap), NUM_PIPES

---
 rtl/game_pkg.sv | 61 ++++++
 rtl/game_gap_gen.sv | 53 +++++
 rtl/game_engine.sv | 246 ++++++++++++++++++++++++
 tb/tb_game_engine.sv | 271 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/game_pkg.sv
// Shared definitions for the game core: one-hot state encoding, default geometry and helpers.
package game_pkg;

  localparam int unsigned PosW = 16;

  // Bit positions inside the one-hot game_state vector.
  localparam int unsigned ST_START = 0;
  localparam int unsigned ST_READY = 1;
  localparam int unsigned ST_FLY   = 2;
  localparam int unsigned ST_OVER  = 3;

  typedef enum logic [3:0] {
    StStart = 4'(1 << ST_START),
    StReady = 4'(1 << ST_READY),
    StFly   = 4'(1 << ST_FLY),
    StOver  = 4'(1 << ST_OVER)
  } state_e;

  typedef logic signed [PosW-1:0] pos_t;

  localparam int DefNumPipes    = 3;
  localparam int DefScreenW     = 640;
  localparam int DefGroundY     = 400;
  localparam int DefBirdX       = 128;
  localparam int DefBirdW       = 34;
  localparam int DefBirdH       = 24;
  localparam int DefPipeW       = 52;
  localparam int DefPipeSpacing = 220;
  localparam int DefGapH        = 120;
  localparam int DefGapMin      = 40;
  localparam int DefGapMax      = 240;
  localparam int DefPipeSpeed   = 5;
  localparam int DefGravity     = 1;
  localparam int DefMaxFall     = 10;
  localparam int DefFlapVel     = 9;

  localparam int StartX     = 600;
  localparam int StartY     = 380;
  localparam int ReadyY     = 200;
  localparam int GapStep    = 67;
  localparam int AnimFrames = 6;

  localparam logic [15:0] LfsrSeed = 16'hACE1;

  function automatic pos_t vel_ext(input logic signed [7:0] vel);
    return {{(PosW - 8){vel[7]}}, vel};
  endfunction

  // Sprite tilt follows velocity (8 units per px/frame), limited to +-64.
  function automatic logic signed [7:0] angle_of(input logic signed [7:0] vel);
    logic signed [15:0] a;
    a = {{5{vel[7]}}, vel, 3'b000};
    if (a > 16'sd64) begin
      return 8'sd64;
    end else if (a < -16'sd64) begin
      return -8'sd64;
    end
    return a[7:0];
  endfunction

endpackage

// File: rtl/game_gap_gen.sv
// Gap-top generator for recycled pipes. GAME_RAND_GAP_EN selects an LFSR source; otherwise a
// fixed +GapStep walk wrapping inside [GapMin, GapMax] advances on each next_i pulse.
module game_gap_gen
  import game_pkg::*;
#(
  parameter int GapMin = DefGapMin,
  parameter int GapMax = DefGapMax
) (
  input  logic clk_i,
  input  logic rst_i,
  input  logic next_i,
  output pos_t gap_o
);

  localparam int Span = GapMax - GapMin + 1;

`ifdef GAME_RAND_GAP_EN
  logic [15:0] lfsr_q;
  logic        unused_next;

  assign unused_next = next_i;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      lfsr_q <= LfsrSeed;
    end else begin
      lfsr_q <= {lfsr_q[14:0], lfsr_q[15] ^ lfsr_q[13] ^ lfsr_q[12] ^ lfsr_q[10]};
    end
  end

  assign gap_o = pos_t'(GapMin) + pos_t'(lfsr_q % 16'(Span));
`else
  localparam pos_t GapMinP = pos_t'(GapMin);
  localparam pos_t GapMaxP = pos_t'(GapMax);
  localparam pos_t SpanP   = pos_t'(Span);
  localparam pos_t StepP   = pos_t'(GapStep);

  pos_t gap_q;
  pos_t step;

  assign step  = gap_q + StepP;
  assign gap_o = (step > GapMaxP) ? step - SpanP : step;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      gap_q <= GapMinP;
    end else if (next_i) begin
      gap_q <= gap_o;
    end
  end
`endif

endmodule

// File: rtl/game_engine.sv
// Flappy Bird game core: one-hot FSM, bird physics, scrolling pipes, collision and score.
// Gap source for recycled pipes is chosen by GAME_RAND_GAP_EN inside game_gap_gen.
module game_engine
  import game_pkg::*;
#(
  parameter int NumPipes    = DefNumPipes,
  parameter int ScreenW     = DefScreenW,
  parameter int GroundY     = DefGroundY,
  parameter int BirdX       = DefBirdX,
  parameter int BirdW       = DefBirdW,
  parameter int BirdH       = DefBirdH,
  parameter int PipeW       = DefPipeW,
  parameter int PipeSpacing = DefPipeSpacing,
  parameter int GapH        = DefGapH,
  parameter int GapMin      = DefGapMin,
  parameter int GapMax      = DefGapMax,
  parameter int PipeSpeed   = DefPipeSpeed,
  parameter int Gravity     = DefGravity,
  parameter int MaxFall     = DefMaxFall,
  parameter int FlapVel     = DefFlapVel
) (
  input  logic                       clk_i,
  input  logic                       rst_i,
  input  logic                       button_pulse_i,
  input  logic                       new_frame_i,
  output logic [3:0]                 game_state_o,
  output logic [7:0]                 stage_shift_o,
  output logic [1:0]                 bird_status_o,
  output logic signed [PosW-1:0]     bird_pos_x_o,
  output logic signed [PosW-1:0]     bird_pos_y_o,
  output logic signed [7:0]          bird_angle_o,
  output logic [PosW*NumPipes-1:0]   pipe_pos_x_o,
  output logic [PosW*NumPipes-1:0]   pipe_pos_y_o,
  output logic [15:0]                score_o
);

  localparam pos_t BirdXP     = pos_t'(BirdX);
  localparam pos_t BirdWP     = pos_t'(BirdW);
  localparam pos_t BirdHP     = pos_t'(BirdH);
  localparam pos_t PipeWP     = pos_t'(PipeW);
  localparam pos_t GapHP      = pos_t'(GapH);
  localparam pos_t GroundYP   = pos_t'(GroundY);
  localparam pos_t GroundTopP = pos_t'(GroundY - BirdH);
  localparam pos_t SpeedP     = pos_t'(PipeSpeed);
  localparam pos_t LoopP      = pos_t'(NumPipes * PipeSpacing);

  localparam logic signed [7:0] GravV    = 8'(Gravity);
  localparam logic signed [7:0] MaxFallV = 8'(MaxFall);
  localparam logic signed [7:0] FlapV    = 8'(-FlapVel);

  state_e            state_q, state_d;
  logic              frame_q, btn_q, btn_d;
  logic [7:0]        shift_q, shift_d;
  logic [2:0]        cnt_q, cnt_d;
  logic [1:0]        ph_q, ph_d;
  pos_t              bird_x_q, bird_x_d, bird_y_q, bird_y_d;
  logic signed [7:0] vel_q, vel_d, angle_q, angle_d;
  logic [15:0]       score_q, score_d;
  pos_t              pipe_x_q [NumPipes];
  pos_t              pipe_x_d [NumPipes];
  pos_t              pipe_y_q [NumPipes];
  pos_t              pipe_y_d [NumPipes];
  pos_t              x_new    [NumPipes];
  pos_t              y_new    [NumPipes];
  logic [NumPipes-1:0] wrap, pass, hit;

  pos_t gap;
  logic gap_next;

  game_gap_gen #(
    .GapMin(GapMin),
    .GapMax(GapMax)
  ) u_gap_gen (
    .clk_i (clk_i),
    .rst_i (rst_i),
    .next_i(gap_next),
    .gap_o (gap)
  );

  // Bird physics, shared by FLY (with flap) and OVER (free fall to the ground).
  logic signed [7:0] vel_inc, vel_fall, vel_fly;
  pos_t              y_fly_sum, fly_y, y_fall, over_y;
  logic              ground_hit, on_ground, hit_any;

  assign vel_inc    = vel_q + GravV;
  assign vel_fall   = (vel_inc > MaxFallV) ? MaxFallV : vel_inc;
  assign vel_fly    = btn_q ? FlapV : vel_fall;
  assign y_fly_sum  = bird_y_q + vel_ext(vel_fly);
  assign fly_y      = y_fly_sum[PosW-1] ? '0 : y_fly_sum;
  assign y_fall     = bird_y_q + vel_ext(vel_fall);
  assign over_y     = (y_fall > GroundTopP) ? GroundTopP : y_fall;
  assign ground_hit = (fly_y + BirdHP >= GroundYP);
  assign on_ground  = (bird_y_q + BirdHP >= GroundYP);
  assign hit_any    = ground_hit | (|hit);

  for (genvar i = 0; i < NumPipes; i++) begin : g_pipe
    pos_t x_scr;
    assign x_scr    = pipe_x_q[i] - SpeedP;
    assign wrap[i]  = (x_scr < -PipeWP);
    assign x_new[i] = wrap[i] ? x_scr + LoopP : x_scr;
    assign y_new[i] = wrap[i] ? gap : pipe_y_q[i];
    // Scored when the trailing edge moves from at/right of the bird to left of it.
    assign pass[i]  = (pipe_x_q[i] + PipeWP >= BirdXP) && (x_scr + PipeWP < BirdXP);
    assign hit[i]   = (x_new[i] < BirdXP + BirdWP) && (x_new[i] + PipeWP > BirdXP) &&
                      ((fly_y < y_new[i]) || (fly_y + BirdHP > y_new[i] + GapHP));

    assign pipe_pos_x_o[PosW*i +: PosW] = pipe_x_q[i];
    assign pipe_pos_y_o[PosW*i +: PosW] = pipe_y_q[i];
  end

  logic [3:0]  pass_cnt;
  logic [16:0] score_sum;
  logic [15:0] score_new;

  always_comb begin
    pass_cnt = '0;
    for (int i = 0; i < NumPipes; i++) begin
      pass_cnt = pass_cnt + 4'(pass[i]);
    end
  end

  assign score_sum = {1'b0, score_q} + 17'(pass_cnt);
  assign score_new = score_sum[16] ? 16'hFFFF : score_sum[15:0];

  // A press is held until the next update so it is never lost between frames.
  assign btn_d = button_pulse_i | (btn_q & ~frame_q);

  always_comb begin
    state_d  = state_q;
    shift_d  = shift_q;
    cnt_d    = cnt_q;
    ph_d     = ph_q;
    bird_x_d = bird_x_q;
    bird_y_d = bird_y_q;
    vel_d    = vel_q;
    angle_d  = angle_q;
    score_d  = score_q;
    pipe_x_d = pipe_x_q;
    pipe_y_d = pipe_y_q;
    gap_next = 1'b0;

    if (frame_q) begin
      if (state_q != StOver) begin
        shift_d = shift_q + 8'(PipeSpeed);
        if (cnt_q == 3'(AnimFrames - 1)) begin
          cnt_d = '0;
          ph_d  = ph_q + 2'd1;
        end else begin
          cnt_d = cnt_q + 3'd1;
        end
      end

      case (state_q)
        StStart: begin
          if (btn_q) begin
            state_d  = StReady;
            bird_x_d = BirdXP;
            bird_y_d = pos_t'(ReadyY);
            vel_d    = '0;
            angle_d  = '0;
            score_d  = '0;
            for (int i = 0; i < NumPipes; i++) begin
              pipe_x_d[i] = pos_t'(ScreenW + i * PipeSpacing);
              pipe_y_d[i] = pos_t'(GapMin);
            end
          end
        end
        StReady: begin
          if (btn_q) begin
            state_d = StFly;
          end
        end
        StFly: begin
          vel_d    = vel_fly;
          bird_y_d = fly_y;
          angle_d  = angle_of(vel_fly);
          pipe_x_d = x_new;
          pipe_y_d = y_new;
          gap_next = |wrap;
          score_d  = score_new;
          if (hit_any) begin
            state_d = StOver;
          end
        end
        StOver: begin
          if (btn_q && on_ground) begin
            state_d  = StStart;
            bird_x_d = pos_t'(StartX);
            bird_y_d = pos_t'(StartY);
            vel_d    = '0;
            angle_d  = '0;
          end else begin
            vel_d    = vel_fall;
            bird_y_d = over_y;
            angle_d  = angle_of(vel_fall);
          end
        end
        default: state_d = StStart;
      endcase
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q  <= StStart;
      frame_q  <= 1'b0;
      btn_q    <= 1'b0;
      shift_q  <= '0;
      cnt_q    <= '0;
      ph_q     <= '0;
      bird_x_q <= pos_t'(StartX);
      bird_y_q <= pos_t'(StartY);
      vel_q    <= '0;
      angle_q  <= '0;
      score_q  <= '0;
      for (int i = 0; i < NumPipes; i++) begin
        pipe_x_q[i] <= pos_t'(ScreenW + i * PipeSpacing);
        pipe_y_q[i] <= pos_t'(GapMin);
      end
    end else begin
      state_q  <= state_d;
      frame_q  <= new_frame_i;
      btn_q    <= btn_d;
      shift_q  <= shift_d;
      cnt_q    <= cnt_d;
      ph_q     <= ph_d;
      bird_x_q <= bird_x_d;
      bird_y_q <= bird_y_d;
      vel_q    <= vel_d;
      angle_q  <= angle_d;
      score_q  <= score_d;
      pipe_x_q <= pipe_x_d;
      pipe_y_q <= pipe_y_d;
    end
  end

  // Wing frames cycle 0,1,2,1.
  assign bird_status_o = (ph_q == 2'd3) ? 2'd1 : ph_q;
  assign game_state_o  = state_q;
  assign stage_shift_o = shift_q;
  assign bird_pos_x_o  = bird_x_q;
  assign bird_pos_y_o  = bird_y_q;
  assign bird_angle_o  = angle_q;
  assign score_o       = score_q;

endmodule

// File: tb/tb_game_engine.sv
// Bench for game_engine: randomized press/frame timing, frame-level reference model, autopilot
// flight through recycled pipes, collision, OVER handling and asynchronous reset.
module tb_game_engine;

  localparam int NP          = 3;
  localparam int SCREEN_W    = 640;
  localparam int GROUND_Y    = 400;
  localparam int BIRD_X      = 128;
  localparam int BIRD_W      = 34;
  localparam int BIRD_H      = 24;
  localparam int PIPE_W      = 52;
  localparam int PIPE_SPACE  = 220;
  localparam int GAP_H       = 120;
  localparam int GAP_MIN     = 40;
  localparam int GAP_MAX     = 240;
  localparam int PIPE_SPEED  = 5;
  localparam int GRAVITY     = 1;
  localparam int MAX_FALL    = 10;
  localparam int FLAP_VEL    = 9;

  localparam int M_START = 0;
  localparam int M_READY = 1;
  localparam int M_FLY   = 2;
  localparam int M_OVER  = 3;

  logic clk = 1'b0;
  logic rst = 1'b0;
  logic button_pulse = 1'b0;
  logic new_frame = 1'b0;

  logic [3:0]             game_state;
  logic [7:0]             stage_shift;
  logic [1:0]             bird_status;
  logic signed [15:0]     bird_pos_x, bird_pos_y;
  logic signed [7:0]      bird_angle;
  logic [16*NP-1:0]       pipe_pos_x, pipe_pos_y;
  logic [15:0]            score;

  int n_checks = 0;
  int n_fail   = 0;

  // Reference model state.
  int m_st, m_shift, m_frames, m_bx, m_by, m_vel, m_ang, m_score, m_gap, rand_gap;
  int m_px [NP];
  int m_py [NP];
  int wing_seq [4] = '{0, 1, 2, 1};

  game_engine u_dut (
    .clk_i         (clk),
    .rst_i         (rst),
    .button_pulse_i(button_pulse),
    .new_frame_i   (new_frame),
    .game_state_o  (game_state),
    .stage_shift_o (stage_shift),
    .bird_status_o (bird_status),
    .bird_pos_x_o  (bird_pos_x),
    .bird_pos_y_o  (bird_pos_y),
    .bird_angle_o  (bird_angle),
    .pipe_pos_x_o  (pipe_pos_x),
    .pipe_pos_y_o  (pipe_pos_y),
    .score_o       (score)
  );

  always #5 clk = ~clk;

`ifdef GAME_RAND_GAP_EN
  logic [15:0] lfsr_m;
  always @(posedge clk or posedge rst) begin
    if (rst) lfsr_m <= 16'hACE1;
    else     lfsr_m <= {lfsr_m[14:0], lfsr_m[15] ^ lfsr_m[13] ^ lfsr_m[12] ^ lfsr_m[10]};
  end
`endif

  task automatic check(input string tag, input int got, input int exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  function automatic int clamp(input int v, input int lo, input int hi);
    return (v < lo) ? lo : ((v > hi) ? hi : v);
  endfunction

  task automatic reset_pipes();
    for (int i = 0; i < NP; i++) begin
      m_px[i] = SCREEN_W + i * PIPE_SPACE;
      m_py[i] = GAP_MIN;
    end
  endtask

  task automatic model_reset();
    m_st = M_START; m_shift = 0; m_frames = 0; m_bx = 600; m_by = 380;
    m_vel = 0; m_ang = 0; m_score = 0; m_gap = GAP_MIN;
    reset_pipes();
  endtask

  task automatic model_update(input bit flag);
    int  gain;
    int  g;
    bit  hit;
    bit  any_wrap;
    gain = 0; hit = 0; any_wrap = 0;
`ifdef GAME_RAND_GAP_EN
    g = rand_gap;
`else
    g = m_gap + 67;
    if (g > GAP_MAX) g -= (GAP_MAX - GAP_MIN + 1);
`endif
    if (m_st != M_OVER) begin
      m_shift = (m_shift + PIPE_SPEED) % 256;
      m_frames++;
    end
    case (m_st)
      M_START: if (flag) begin
        m_st = M_READY; m_bx = BIRD_X; m_by = 200; m_vel = 0; m_ang = 0; m_score = 0;
        reset_pipes();
      end
      M_READY: if (flag) m_st = M_FLY;
      M_FLY: begin
        m_vel = flag ? -FLAP_VEL : clamp(m_vel + GRAVITY, -128, MAX_FALL);
        m_by  = clamp(m_by + m_vel, 0, 1 << 20);
        m_ang = clamp(m_vel * 8, -64, 64);
        for (int i = 0; i < NP; i++) begin
          int ox;
          ox = m_px[i];
          m_px[i] -= PIPE_SPEED;
          if (ox + PIPE_W >= BIRD_X && m_px[i] + PIPE_W < BIRD_X) gain++;
          if (m_px[i] < -PIPE_W) begin
            m_px[i] += NP * PIPE_SPACE;
            m_py[i] = g;
            any_wrap = 1;
          end
        end
        if (any_wrap) m_gap = g;
        m_score = clamp(m_score + gain, 0, 65535);
        if (m_by + BIRD_H >= GROUND_Y) hit = 1;
        for (int i = 0; i < NP; i++) begin
          if (m_px[i] < BIRD_X + BIRD_W && m_px[i] + PIPE_W > BIRD_X &&
              (m_by < m_py[i] || m_by + BIRD_H > m_py[i] + GAP_H)) hit = 1;
        end
        if (hit) m_st = M_OVER;
      end
      default: begin
        if (flag && m_by + BIRD_H >= GROUND_Y) begin
          m_st = M_START; m_bx = 600; m_by = 380; m_vel = 0; m_ang = 0;
        end else begin
          m_vel = clamp(m_vel + GRAVITY, -128, MAX_FALL);
          m_by  = clamp(m_by + m_vel, -32768, GROUND_Y - BIRD_H);
          m_ang = clamp(m_vel * 8, -64, 64);
        end
      end
    endcase
  endtask

  task automatic check_all(input string tag);
    check({tag, ".state"}, game_state, 1 << m_st);
    check({tag, ".shift"}, stage_shift, m_shift);
    check({tag, ".wing"}, bird_status, wing_seq[(m_frames / 6) % 4]);
    check({tag, ".bx"}, bird_pos_x, m_bx);
    check({tag, ".by"}, bird_pos_y, m_by);
    check({tag, ".angle"}, bird_angle, m_ang);
    check({tag, ".score"}, score, m_score);
    for (int i = 0; i < NP; i++) begin
      check($sformatf("%s.px%0d", tag, i), $signed(pipe_pos_x[16*i +: 16]), m_px[i]);
      check($sformatf("%s.py%0d", tag, i), $signed(pipe_pos_y[16*i +: 16]), m_py[i]);
    end
  endtask

  // Presses land between frames with random spacing; update is two edges after new_frame.
  task automatic do_frame(input int presses, input string tag);
    int idle;
    for (int k = 0; k < presses; k++) begin
      button_pulse = 1'b1;
      @(negedge clk);
      button_pulse = 1'b0;
      idle = $urandom_range(0, 2);
      repeat (idle) @(negedge clk);
    end
    idle = $urandom_range(1, 4);
    repeat (idle) @(negedge clk);
    new_frame = 1'b1;
    @(negedge clk);
    new_frame = 1'b0;
`ifdef GAME_RAND_GAP_EN
    rand_gap = GAP_MIN + int'(lfsr_m % 16'd201);
`endif
    @(negedge clk);
    model_update(presses > 0);
    check_all(tag);
  endtask

  // Steer the bird around a target height relative to the next unpassed pipe's gap top.
  function automatic int pilot(input int offset);
    int best;
    int thr;
    best = 0;
    for (int i = 0; i < NP; i++) begin
      if (m_px[i] + PIPE_W >= BIRD_X &&
          (m_px[best] + PIPE_W < BIRD_X || m_px[i] < m_px[best])) best = i;
    end
    thr = m_py[best] + offset + int'($urandom_range(0, 20));
    return (m_by > thr) ? int'($urandom_range(1, 2)) : 0;
  endfunction

  initial begin
    int n;
    int saved_score;
    #2 rst = 1'b1;
    #1;
    model_reset();
    check_all("reset");
    @(negedge clk);
    rst = 1'b0;

    do_frame(2, "two_press");
    check("two_press_one_step", game_state, 4'b0010);
    do_frame(1, "ready_to_fly");
    for (int f = 0; f < 3; f++) do_frame(0, "fly_idle");
    check("fly_y_after3", bird_pos_y, 206);
    check("fly_angle_after3", bird_angle, 24);
    do_frame(1, "flap");
    check("flap_angle", bird_angle, -64);

    for (int f = 0; f < 300; f++) do_frame(pilot(56), "pilot");

    // Fly above the gap so the bird strikes a pipe in mid-air.
    n = 0;
    while (m_st == M_FLY && n < 300) begin
      do_frame(pilot(-20), "to_crash");
      n++;
    end
    check("reach_over", game_state, 4'b1000);

    if (m_by + BIRD_H < GROUND_Y) begin
      do_frame(1, "over_air_press");
      check("air_press_ignored", game_state, 4'b1000);
    end
    n = 0;
    while (m_st == M_OVER && m_by + BIRD_H < GROUND_Y && n < 100) begin
      do_frame(0, "over_fall");
      n++;
    end
    check("on_ground_y", bird_pos_y, GROUND_Y - BIRD_H);
    saved_score = m_score;
    do_frame(1, "over_to_start");
    check("start_keeps_score", score, saved_score);
    check("back_to_start", game_state, 4'b0001);
    do_frame(1, "start_to_ready");
    check("ready_clears_score", score, 0);
    do_frame(1, "fly_again");
    for (int f = 0; f < 4; f++) do_frame(0, "fly_pre_reset");
    check("pre_reset_fly", game_state, 4'b0100);

    #3 rst = 1'b1;
    #1;
    model_reset();
    check_all("async_reset");
    @(negedge clk);
    rst = 1'b0;

    for (int f = 0; f < 60; f++) begin
      do_frame(($urandom_range(0, 3) == 0) ? int'($urandom_range(1, 3)) : 0, "rand_tail");
    end

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
